// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing BRAM port A between the core (m0) and the debug loader (m1),
// with a bounded burst allowance and per-master routing of 1-cycle read returns.
module dmem_arbiter #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned BURST_MAX = 4
) (
   input  logic              clk_i,
   input  logic              rstn_i,

   input  logic              m0_req_i,
   input  logic [3:0]        m0_we_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_gnt_o,
   output logic              m0_rvalid_o,
   output logic [DATA_W-1:0] m0_rdata_o,

   input  logic              m1_req_i,
   input  logic [3:0]        m1_we_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_gnt_o,
   output logic              m1_rvalid_o,
   output logic [DATA_W-1:0] m1_rdata_o,

   output logic [3:0]        mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_din_o,
   input  logic [DATA_W-1:0] mem_dout_i
);

   typedef enum logic {
      OWN_M0 = 1'b0,
      OWN_M1 = 1'b1
   } owner_t;

   localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);
   localparam logic [3:0] BURST_SAT = 4'hF;

   owner_t     owner, owner_nxt, granted;
   logic [3:0] burst_cnt, burst_nxt;
   logic       rvalid0, rvalid1, rvalid0_nxt, rvalid1_nxt;
   logic       gnt0, gnt1;
   logic       acc0, acc1;

   // State register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         owner     <= OWN_M0;
         burst_cnt <= '0;
         rvalid0   <= 1'b0;
         rvalid1   <= 1'b0;
      end else begin
         owner     <= owner_nxt;
         burst_cnt <= burst_nxt;
         rvalid0   <= rvalid0_nxt;
         rvalid1   <= rvalid1_nxt;
      end
   end

   // Grant selection; grants are forced low while reset is asserted
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rstn_i) begin
         case ({m1_req_i, m0_req_i})
            2'b01: gnt0 = 1'b1;
            2'b10: gnt1 = 1'b1;
            2'b11: begin
               if (burst_cnt < BURST_LIM) begin
                  gnt0 = (owner == OWN_M0);
                  gnt1 = (owner == OWN_M1);
               end else begin
                  gnt0 = (owner == OWN_M1);
                  gnt1 = (owner == OWN_M0);
               end
            end
            default: ;
         endcase
      end
   end

   assign acc0 = m0_req_i & gnt0;
   assign acc1 = m1_req_i & gnt1;

   // Next-state: owner/burst tracking and read-return tagging
   always_comb begin
      owner_nxt   = owner;
      burst_nxt   = burst_cnt;
      granted     = acc1 ? OWN_M1 : OWN_M0;
      rvalid0_nxt = acc0 && (m0_we_i == '0);
      rvalid1_nxt = acc1 && (m1_we_i == '0);
      if (acc0 || acc1) begin
         if (granted == owner) begin
            burst_nxt = (burst_cnt == BURST_SAT) ? BURST_SAT : burst_cnt + 4'd1;
         end else begin
            owner_nxt = granted;
            burst_nxt = 4'd1;
         end
      end
   end

   // Outputs: memory request mux and read return routing
   always_comb begin
      mem_we_o   = '0;
      mem_addr_o = '0;
      mem_din_o  = '0;
      if (gnt0) begin
         mem_we_o   = m0_we_i;
         mem_addr_o = m0_addr_i;
         mem_din_o  = m0_wdata_i;
      end else if (gnt1) begin
         mem_we_o   = m1_we_i;
         mem_addr_o = m1_addr_i;
         mem_din_o  = m1_wdata_i;
      end
   end

   assign m0_gnt_o    = gnt0;
   assign m1_gnt_o    = gnt1;
   assign m0_rvalid_o = rvalid0;
   assign m1_rvalid_o = rvalid1;
   assign m0_rdata_o  = mem_dout_i;
   assign m1_rdata_o  = mem_dout_i;

   a_one_grant : assert property (@(posedge clk_i) disable iff (!rstn_i) !(gnt0 && gnt1));
   a_one_rvalid : assert property (@(posedge clk_i) disable iff (!rstn_i) !(rvalid0 && rvalid1));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural arbiter/memory model.
module tb_dmem_arbiter;
   localparam int BM = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        m0_req, m1_req;
   logic [3:0]  m0_we, m1_we;
   logic [15:0] m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic [3:0]  mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout = '0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(16), .DATA_W(32), .BURST_MAX(BM)) dut (
      .clk_i(clk), .rstn_i(rstn),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
      .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
      .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
      .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_din_o(mem_din), .mem_dout_i(mem_dout)
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Read-first BRAM driven only by the DUT's memory outputs
   logic [31:0] bram [0:16383];
   always @(posedge clk) begin
      mem_dout <= bram[mem_addr[15:2]];
      if (mem_we != 4'h0) bram[mem_addr[15:2]] <= merge(bram[mem_addr[15:2]], mem_din, mem_we);
   end

   // Reference model: who last won, how long their streak is, and a shadow memory
   logic [31:0] ref_mem [0:16383];
   int          own = 0, run = 0, exp_g = -1;
   logic        pend0 = 1'b0, pend1 = 1'b0;
   logic [31:0] pend_d0 = '0, pend_d1 = '0;
   logic [3:0]  e_we;
   logic [15:0] e_addr;
   logic [31:0] e_din;

   always @(negedge clk) begin
      if (!rstn) exp_g = -1;
      else if (m0_req && !m1_req) exp_g = 0;
      else if (m1_req && !m0_req) exp_g = 1;
      else if (m0_req && m1_req) exp_g = (run < BM) ? own : 1 - own;
      else exp_g = -1;
      e_we = 4'h0; e_addr = 16'h0; e_din = 32'h0;
      if (exp_g == 0) begin e_we = m0_we; e_addr = m0_addr; e_din = m0_wdata; end
      if (exp_g == 1) begin e_we = m1_we; e_addr = m1_addr; e_din = m1_wdata; end
      chk("gnt0", 32'(m0_gnt), 32'(exp_g == 0));
      chk("gnt1", 32'(m1_gnt), 32'(exp_g == 1));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_din", mem_din, e_din);
      chk("rvalid0", 32'(m0_rvalid), 32'(pend0 && rstn));
      chk("rvalid1", 32'(m1_rvalid), 32'(pend1 && rstn));
      if (pend0 && rstn) chk("rdata0", m0_rdata, pend_d0);
      if (pend1 && rstn) chk("rdata1", m1_rdata, pend_d1);
   end

   always @(posedge clk) begin
      if (!rstn) begin
         own = 0; run = 0; pend0 = 1'b0; pend1 = 1'b0;
      end else begin
         pend0 = (exp_g == 0) && (m0_we == 4'h0);
         pend1 = (exp_g == 1) && (m1_we == 4'h0);
         pend_d0 = ref_mem[m0_addr[15:2]];
         pend_d1 = ref_mem[m1_addr[15:2]];
         if (exp_g >= 0) begin
            if (exp_g == own) run = (run < 15) ? run + 1 : 15;
            else begin own = exp_g; run = 1; end
            if (exp_g == 0 && m0_we != 4'h0)
               ref_mem[m0_addr[15:2]] = merge(ref_mem[m0_addr[15:2]], m0_wdata, m0_we);
            if (exp_g == 1 && m1_we != 4'h0)
               ref_mem[m1_addr[15:2]] = merge(ref_mem[m1_addr[15:2]], m1_wdata, m1_we);
         end
      end
   end

   task automatic tick(); @(posedge clk); #1; endtask
   task automatic sample(); @(negedge clk); endtask
   task automatic drv0(input logic r, input logic [3:0] we, input logic [15:0] a, input logic [31:0] d);
      m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d;
   endtask
   task automatic drv1(input logic r, input logic [3:0] we, input logic [15:0] a, input logic [31:0] d);
      m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d;
   endtask
   task automatic idle(); drv0(1'b0, 4'h0, 16'h0, 32'h0); drv1(1'b0, 4'h0, 16'h0, 32'h0); endtask
   task automatic reset_pulse(); tick(); rstn = 1'b0; idle(); tick(); rstn = 1'b1; endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int   i0, i1;
   int   contend_seq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
   logic sw_r0 [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
   logic sw_r1 [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
   int   sw_exp [4] = '{0, 0, 1, 1};
   logic g0_seen, g1_seen;

   initial begin
      for (int i = 0; i < 16384; i++) begin bram[i] = '0; ref_mem[i] = '0; end
      bram[4] = 32'hDEADBEEF;
      ref_mem[4] = 32'hDEADBEEF;
      rstn = 1'b0;
      drv0(1'b1, 4'h0, 16'h0020, 32'h0);
      drv1(1'b1, 4'h0, 16'h0024, 32'h0);

      // Reset held with both requesting
      repeat (2) begin
         tick(); sample();
         chk("rst_gnt0", 32'(m0_gnt), 32'd0);
         chk("rst_gnt1", 32'(m1_gnt), 32'd0);
         chk("rst_mem_we", 32'(mem_we), 32'd0);
         chk("rst_rvalid0", 32'(m0_rvalid), 32'd0);
      end
      tick(); rstn = 1'b1; sample();
      chk("first_gnt0", 32'(m0_gnt), 32'd1);
      chk("first_gnt1", 32'(m1_gnt), 32'd0);
      tick(); idle(); sample();
      chk("first_rvalid0", 32'(m0_rvalid), 32'd1);
      chk("idle_mem_we", 32'(mem_we), 32'd0);

      // Solo read of preloaded word
      reset_pulse();
      tick(); drv0(1'b1, 4'h0, 16'h0010, 32'h0); sample();
      chk("solo_gnt0", 32'(m0_gnt), 32'd1);
      chk("solo_addr", 32'(mem_addr), 32'h10);
      tick(); idle(); sample();
      chk("solo_rvalid0", 32'(m0_rvalid), 32'd1);
      chk("solo_rdata0", m0_rdata, 32'hDEADBEEF);
      chk("solo_rvalid1", 32'(m1_rvalid), 32'd0);

      // Contention: four m0 then four m1 then m0
      reset_pulse();
      i0 = 0; i1 = 0;
      for (int k = 0; k < 9; k++) begin
         tick();
         drv0(1'b1, 4'h0, 16'(16'h40 + 4 * i0), 32'h0);
         drv1(1'b1, 4'h0, 16'(16'h80 + 4 * i1), 32'h0);
         sample();
         chk("contend_gnt0", 32'(m0_gnt), 32'(contend_seq[k] == 0));
         if (m0_gnt) i0++;
         if (m1_gnt) i1++;
      end
      tick(); idle();

      // m1 write then read back
      tick(); drv1(1'b1, 4'hF, 16'h0100, 32'h12345678); sample();
      chk("wr_gnt1", 32'(m1_gnt), 32'd1);
      chk("wr_mem_we", 32'(mem_we), 32'hF);
      chk("wr_mem_din", mem_din, 32'h12345678);
      tick(); drv1(1'b1, 4'h0, 16'h0100, 32'h0); sample();
      chk("rd_gnt1", 32'(m1_gnt), 32'd1);
      chk("wr_no_rvalid1", 32'(m1_rvalid), 32'd0);
      tick(); idle(); sample();
      chk("rd_rvalid1", 32'(m1_rvalid), 32'd1);
      chk("rd_rdata1", m1_rdata, 32'h12345678);

      // Owner switch: m0,m0 then m1 alone then both -> m1 keeps ownership
      reset_pulse();
      for (int k = 0; k < 4; k++) begin
         tick();
         drv0(sw_r0[k], 4'h0, 16'h0200, 32'h0);
         drv1(sw_r1[k], 4'h0, 16'h0204, 32'h0);
         sample();
         chk("switch_gnt0", 32'(m0_gnt), 32'(sw_exp[k] == 0));
         chk("switch_gnt1", 32'(m1_gnt), 32'(sw_exp[k] == 1));
      end

      // Reset landing on pending read returns
      tick(); idle();
      tick(); drv0(1'b1, 4'h0, 16'h0010, 32'h0); sample();
      chk("mid_gnt0", 32'(m0_gnt), 32'd1);
      tick(); idle(); rstn = 1'b0; sample();
      chk("mid_rvalid0", 32'(m0_rvalid), 32'd0);
      tick(); rstn = 1'b1; drv1(1'b1, 4'h0, 16'h0014, 32'h0); sample();
      chk("mid_gnt1", 32'(m1_gnt), 32'd1);
      tick(); idle(); rstn = 1'b0; sample();
      chk("mid_rvalid1", 32'(m1_rvalid), 32'd0);
      tick(); rstn = 1'b1;
      drv0(1'b1, 4'h0, 16'h0018, 32'h0); drv1(1'b1, 4'h0, 16'h001C, 32'h0); sample();
      chk("post_rst_gnt0", 32'(m0_gnt), 32'd1);
      chk("post_rst_gnt1", 32'(m1_gnt), 32'd0);

      // Randomized traffic; a master holds its request until granted (or occasionally drops it)
      g0_seen = m0_gnt; g1_seen = m1_gnt;
      for (int c = 0; c < 3000; c++) begin
         tick();
         rstn = ($urandom_range(0, 299) != 0);
         if (!(m0_req && !g0_seen && $urandom_range(0, 19) != 0))
            drv0($urandom_range(0, 9) < 7, $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)),
                 16'($urandom_range(0, 63) << 2), $urandom);
         if (!(m1_req && !g1_seen && $urandom_range(0, 19) != 0))
            drv1($urandom_range(0, 9) < 7, $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)),
                 16'($urandom_range(0, 63) << 2), $urandom);
         sample();
         g0_seen = m0_gnt; g1_seen = m1_gnt;
      end

      tick(); rstn = 1'b1; idle();
      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
